stdout_uart_tx: RTL and testbench

Downstream consumer of the system's stdout stream (val/data/rdy). Each accepted 16-bit word is converted to four uppercase ASCII hex digits (MSB nibble first), followed by CR LF. The six characters go out as 8N1 UART frames on a single TX pin. It applies backpressure through `stdout_rdy_o`, so the core stalls on stdout writes until the previous word has been fully serialized.

---
 rtl/stdout_uart_tx_if.sv | 10 +
 rtl/stdout_uart_tx.sv | 129 ++++++++++++
 tb/tb_stdout_uart_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/stdout_uart_tx_if.sv
// stdout stream handshake: the core offers a 16-bit word with val, the
// consumer accepts it on any rising edge where rdy is also high.
interface stdout_uart_tx_if;
  logic        val;
  logic [15:0] data;
  logic        rdy;

  modport master (output val, output data, input rdy);
  modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/stdout_uart_tx.sv
// Prints each accepted stdout word as four uppercase hex digits plus CR LF,
// serialized as 8N1 UART frames; stalls the core until the word is sent.
module stdout_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk_i,
  input  logic             rst_i,
  stdout_uart_tx_if.slave  stdout_if,
  output logic             uart_tx_o,
  output logic             busy_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST     = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] LF_STOP_LAST = TW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    IDX_LAST     = 3'd5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     word_q, word_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      bit_q, bit_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tx_q, tx_d;
  logic [7:0]      char_cur;
  logic            accept;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign stdout_if.rdy = (state_q == IDLE) && !rst_i;
  assign accept        = stdout_if.val && stdout_if.rdy;
  assign uart_tx_o     = tx_q;
  assign busy_o        = (state_q != IDLE);

  always_comb begin
    case (idx_q)
      3'd0:    char_cur = hex_ascii(word_q[15:12]);
      3'd1:    char_cur = hex_ascii(word_q[11:8]);
      3'd2:    char_cur = hex_ascii(word_q[7:4]);
      3'd3:    char_cur = hex_ascii(word_q[3:0]);
      3'd4:    char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    timer_d = timer_q + TW'(1);
    tx_d    = tx_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (accept) begin
          word_d  = stdout_if.data;
          idx_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = char_cur[0];
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = char_cur[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        // The LF stop bit hands its final cycle to IDLE, where a waiting word
        // is accepted, so back-to-back words leave no idle gap on the line.
        if (idx_q == IDX_LAST) begin
          if (timer_q == LF_STOP_LAST) begin
            timer_d = '0;
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else if (timer_q == BIT_LAST) begin
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed and randomized checks of stdout_uart_tx against a line-level model
// of the expected 8N1 waveform for each printed word.
module tb_stdout_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stdout_uart_tx_if if4 ();
  stdout_uart_tx_if if2 ();
  logic tx4, busy4, tx2, busy2;

  stdout_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stdout_if(if4), .uart_tx_o(tx4), .busy_o(busy4)
  );
  stdout_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .stdout_if(if2), .uart_tx_o(tx2), .busy_o(busy2)
  );

  int errors = 0;
  int checks = 0;
  bit use2   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cpb();
    return use2 ? 2 : 4;
  endfunction
  function automatic logic tx_s();
    return use2 ? tx2 : tx4;
  endfunction
  function automatic logic rdy_s();
    return use2 ? if2.rdy : if4.rdy;
  endfunction
  function automatic logic busy_s();
    return use2 ? busy2 : busy4;
  endfunction

  task automatic drive(input logic v, input logic [15:0] d);
    if (use2) begin
      if2.val = v; if2.data = d;
    end else begin
      if4.val = v; if4.data = d;
    end
  endtask

  // Reference: the text "%04X\r\n" of the word, one character per index.
  function automatic logic [7:0] exp_char(input logic [15:0] w, input int i);
    int n;
    if (i == 4) return 8'd13;
    if (i == 5) return 8'd10;
    n = int'((w >> (4 * (3 - i))) & 16'hF);
    if (n < 10) return 8'(n + 48);
    return 8'(n - 10 + 65);
  endfunction

  // Offer a word at a negedge; the following posedge is the handshake edge.
  task automatic start_word(input logic [15:0] w, input string tag);
    @(negedge clk);
    drive(1'b1, w);
    check({tag, "_rdy_pre"}, rdy_s(), 1);
    @(posedge clk);
  endtask

  // Sample every cycle of a word's 60*C-cycle window right after its handshake edge.
  task automatic watch(input logic [15:0] w, input bit hold, input logic [15:0] nxt,
                       input bit scramble, input string tag);
    int C, total, k, rdy_k, inv, bad;
    logic [7:0] ch, dec;
    logic lvl;
    C = cpb(); total = 60 * C; rdy_k = -1; inv = 0;
    for (int c = 0; c < 6; c++) begin
      ch = exp_char(w, c); bad = 0; dec = '0;
      for (int s = 0; s < 10; s++) begin
        for (int p = 0; p < C; p++) begin
          @(negedge clk);
          k = c * 10 * C + s * C + p;
          lvl = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : ch[s-1];
          if (tx_s() !== lvl) bad++;
          if (p == C / 2 && s >= 1 && s <= 8) dec[s-1] = tx_s();
          if (rdy_s() && busy_s()) inv++;
          if (rdy_s() && rdy_k < 0) rdy_k = k;
          if (hold) drive(1'b1, (scramble && k != total - 1) ? 16'($urandom) : nxt);
          else      drive(1'b0, 16'($urandom));
        end
      end
      check($sformatf("%s_char%0d", tag, c), dec, ch);
      check($sformatf("%s_frame%0d", tag, c), bad, 0);
    end
    check({tag, "_rdy_return"}, rdy_k + 1, total);
    check({tag, "_rdy_while_busy"}, inv, 0);
  endtask

  initial begin
    logic [15:0] r1, r2, r3;
    if4.val = 1'b0; if4.data = '0; if2.val = 1'b0; if2.data = '0;
    rst = 1'b1;
    #12;
    check("rst_tx4", tx4, 1);
    check("rst_busy4", busy4, 0);
    check("rst_rdy4", if4.rdy, 0);
    check("rst_tx2", tx2, 1);
    check("rst_rdy2", if2.rdy, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy4", if4.rdy, 1);
    check("post_rst_rdy2", if2.rdy, 1);
    check("post_rst_busy4", busy4, 0);
    check("post_rst_tx4", tx4, 1);

    start_word(16'h1A2F, "basic");
    watch(16'h1A2F, 1'b0, 16'h0, 1'b0, "basic");

    start_word(16'h0000, "w0000");
    watch(16'h0000, 1'b0, 16'h0, 1'b0, "w0000");
    start_word(16'h9AF0, "w9af0");
    watch(16'h9AF0, 1'b0, 16'h0, 1'b0, "w9af0");
    start_word(16'hFFFF, "wffff");
    watch(16'hFFFF, 1'b0, 16'h0, 1'b0, "wffff");

    start_word(16'h1234, "b2b_a");
    watch(16'h1234, 1'b1, 16'hBEEF, 1'b0, "b2b_a");
    watch(16'hBEEF, 1'b0, 16'h0, 1'b0, "b2b_b");

    r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
    start_word(r1, "bp1");
    watch(r1, 1'b1, r2, 1'b1, "bp1");
    watch(r2, 1'b1, r3, 1'b1, "bp2");
    watch(r3, 1'b0, 16'h0, 1'b0, "bp3");

    // Third character of 0x5678 is '7' (0x37); its bit 3 is a 0 at sample 97.
    start_word(16'h5678, "midrst");
    for (int k = 0; k < 98; k++) begin
      @(negedge clk);
      drive(1'b0, 16'h0);
    end
    check("midrst_tx_pre", tx4, 0);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx4, 1);
    check("midrst_rdy", if4.rdy, 0);
    check("midrst_busy", busy4, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy_after", if4.rdy, 1);
    check("midrst_busy_after", busy4, 0);
    check("midrst_tx_after", tx4, 1);
    start_word(16'h00C3, "w00c3");
    watch(16'h00C3, 1'b0, 16'h0, 1'b0, "w00c3");

    use2 = 1'b1;
    start_word(16'h5A5A, "min_div");
    watch(16'h5A5A, 1'b0, 16'h0, 1'b0, "min_div");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
